divider_request_scheduler: RTL and testbench
============================================

Name: divider_request_scheduler

Overview:
Shares one non_restoring_division_topmodule instance (16-bit dividend/divisor, 16-bit quotient, 17-bit remainder, start/done) among N requesters. Each requester has a valid/ready request channel. Arbitration is round-robin. The scheduler sequences the divider's start/done protocol, short-circuits divide-by-zero, and runs a watchdog on the divider. Results return on one shared response channel, tagged with the requester ID.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal ceil(log2(N_REQ))
TIMEOUT, 40, max cycles in WAIT before aborting the divider

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_dividend  input  16*N_REQ  requester i in bits [16i+15:16i]
req_divisor  input  16*N_REQ  same packing
div_start  output  1  start pulse to divider
div_dividend  output  16  operand to divider; held stable from ISSUE until leaving WAIT
div_divisor  output  16  operand to divider; held stable same as div_dividend
div_soft_rst  output  1  one-cycle divider reset pulse on timeout
div_done  input  1  divider completion
div_quotient  input  16  divider quotient
div_remainder  input  17  divider remainder
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  ID_W  requester index of the response
resp_quotient  output  16  result quotient
resp_remainder  output  17  result remainder
resp_err  output  2  00 ok, 01 divide-by-zero, 10 timeout
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - All outputs are 0: req_ready, div_start, div_soft_rst, resp_valid, resp_id, resp_quotient, resp_remainder, resp_err, busy, and the operand registers.
  - rst also resets the divider directly. Reset mid-operation drops the in-flight request with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from rr_ptr upward, with wrap-around.
  - req_ready[g]=1 combinationally in that cycle. The handshake completes that same cycle.
  - Operands are latched into registers. Set cur_id=g and rr_ptr=(g+1) mod N_REQ.
  - If the latched divisor is 0, go to RESP with quotient=16'hFFFF, remainder={1'b0,dividend}, err=01. The divider is never started.
  - Otherwise go to ISSUE.
  - With no req_valid, stay in IDLE and keep rr_ptr unchanged.
- ISSUE:
  - div_start=1 for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_done=1, capture div_quotient/div_remainder with err=00 and go to RESP. div_done is sampled only in WAIT; a done in any other state is ignored.
  - If the counter reaches TIMEOUT-1 without done, pulse div_soft_rst for one cycle. Result is quotient=0, remainder=0, err=10; go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - resp_valid=1 and resp_id=cur_id; result registers are stable.
  - Holds until resp_ready=1, then returns to IDLE on the next edge.
  - A new grant can occur one cycle after the response handshake, never in the same cycle.
- req_ready is zero in every state except IDLE. At most one request is outstanding.
- Latency, divide-by-zero: request accept to resp_valid = 1 cycle.
- Latency, normal: request accept to resp_valid = 2 + divider latency cycles.
- Round-robin fairness: continuously requesting agents are each served once per N_REQ grants.
- Requesters must hold valid and data until ready; the scheduler does not check this.

Test Plan:
- Single request on requester 2: dividend=100, divisor=7, resp_ready=1 -> one div_start pulse; response has resp_id=2, quotient=14, remainder=2, err=00.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each gets its correct result; req_ready is never multi-hot.
- Requester 1 sends dividend=0x1234, divisor=0 -> div_start never asserted; resp_valid exactly 1 cycle after accept; quotient=0xFFFF, remainder=0x01234, err=01.
- Stub divider that never asserts done -> div_soft_rst pulses TIMEOUT cycles after div_start; response has err=10, quotient=0; the next request completes normally.
- Hold resp_ready=0 for 10 cycles -> resp_* stable; req_ready stays 0 throughout; IDLE resumes only after the resp_ready handshake.
- Assert rst during WAIT -> all outputs go 0 asynchronously; no response issued; after release, rr_ptr=0 and requester 0 is granted first.

Source files
------------

// File: rtl/divider_request_scheduler_if.sv
// Request, divider and response channels of the shared-divider scheduler.
// slave = scheduler side, master = requesters, divider and response consumer.
interface divider_request_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_dividend;
    logic [16*N_REQ-1:0] req_divisor;
    logic                div_start;
    logic [15:0]         div_dividend;
    logic [15:0]         div_divisor;
    logic                div_soft_rst;
    logic                div_done;
    logic [15:0]         div_quotient;
    logic [16:0]         div_remainder;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [15:0]         resp_quotient;
    logic [16:0]         resp_remainder;
    logic [1:0]          resp_err;
    logic                busy;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  div_done, div_quotient, div_remainder,
        input  resp_ready,
        output req_ready, div_start, div_dividend, div_divisor, div_soft_rst,
        output resp_valid, resp_id, resp_quotient, resp_remainder, resp_err, busy
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        output div_done, div_quotient, div_remainder,
        output resp_ready,
        input  req_ready, div_start, div_dividend, div_divisor, div_soft_rst,
        input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_err, busy
    );
endinterface

// File: rtl/divider_request_scheduler.sv
// Round-robin scheduler sharing one divider among N_REQ requesters, with
// divide-by-zero bypass and a watchdog that soft-resets a hung divider.
//
// state | meaning
// IDLE  | waiting for a request; grants round-robin from rr_ptr
// ISSUE | one-cycle div_start pulse, watchdog cleared
// WAIT  | waiting for div_done or watchdog expiry
// RESP  | result presented on the response channel until accepted
module divider_request_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    divider_request_scheduler_if.slave bus
);
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  cur_id_q;
    logic [15:0]      dividend_q;
    logic [15:0]      divisor_q;
    logic [CNT_W-1:0] wdog_q;
    logic             div_start_q;
    logic             resp_valid_q;
    logic [15:0]      quotient_q;
    logic [16:0]      remainder_q;
    logic [1:0]       err_q;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [15:0]      grant_dividend;
    logic [15:0]      grant_divisor;
    logic             timeout_hit;

    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = ID_W'(idx);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign grant_dividend = bus.req_dividend[16*grant_id +: 16];
    assign grant_divisor  = bus.req_divisor[16*grant_id +: 16];

    // Done on the final watchdog cycle takes priority over the abort.
    assign timeout_hit = (state_q == WAIT) && !bus.div_done && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cur_id_q     <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            wdog_q       <= '0;
            div_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            err_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        cur_id_q   <= grant_id;
                        rr_ptr_q   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        dividend_q <= grant_dividend;
                        divisor_q  <= grant_divisor;
                        if (grant_divisor == 16'd0) begin
                            quotient_q   <= 16'hFFFF;
                            remainder_q  <= {1'b0, grant_dividend};
                            err_q        <= 2'b01;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start_q <= 1'b0;
                    wdog_q      <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (bus.div_done) begin
                        quotient_q   <= bus.div_quotient;
                        remainder_q  <= bus.div_remainder;
                        err_q        <= 2'b00;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (wdog_q == WDOG_LAST) begin
                        quotient_q   <= '0;
                        remainder_q  <= '0;
                        err_q        <= 2'b10;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rst gating keeps req_ready low while reset is held even with valid requests.
    assign bus.req_ready      = (state_q == IDLE && grant_found && !rst) ?
                                (N_REQ'(1) << grant_id) : '0;
    assign bus.div_start      = div_start_q;
    assign bus.div_dividend   = dividend_q;
    assign bus.div_divisor    = divisor_q;
    assign bus.div_soft_rst   = timeout_hit;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_id        = cur_id_q;
    assign bus.resp_quotient  = quotient_q;
    assign bus.resp_remainder = remainder_q;
    assign bus.resp_err       = err_q;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_divider_request_scheduler.sv
// Randomized bench for divider_request_scheduler: behavioural divider stub,
// round-robin reference model and a response scoreboard.
module tb_divider_request_scheduler;
    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_request_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    divider_request_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct {
        int          id;
        logic [15:0] q;
        logic [16:0] r;
        logic [1:0]  err;
        int          acc_cyc;
        int          starts;
    } exp_t;

    op_t  op_q[$];
    exp_t exp_q[$];
    int   acc_log[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic             stuck     = 1'b0;
    int               force_lat = 0;
    int               rr_mode   = 0;
    int               gap       = 0;

    logic [N_REQ-1:0] drv_valid;
    logic [15:0]      drv_a [N_REQ];
    logic [15:0]      drv_b [N_REQ];
    logic             drv_resp_ready;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    assign bus.req_valid  = drv_valid;
    assign bus.resp_ready = drv_resp_ready;
    always_comb begin
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_dividend[16*i +: 16] = drv_a[i];
            bus.req_divisor[16*i +: 16]  = drv_b[i];
        end
    end

    // Divider stub: done L cycles after the start cycle, garbage otherwise.
    logic        dm_active;
    logic [7:0]  dm_cnt;
    logic [15:0] dm_a;
    logic [15:0] dm_b;
    int          dm_lat;
    int          dm_next;
    logic        dm_done;

    assign dm_done = dm_active && !stuck && (dm_cnt == 8'd1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_active <= 1'b0;
            dm_cnt    <= '0;
            dm_a      <= '0;
            dm_b      <= '0;
            dm_lat    <= 0;
            dm_next   <= 3;
        end else if (bus.div_soft_rst) begin
            dm_active <= 1'b0;
        end else if (bus.div_start) begin
            dm_active <= 1'b1;
            dm_a      <= bus.div_dividend;
            dm_b      <= bus.div_divisor;
            dm_lat    <= (force_lat != 0) ? force_lat : dm_next;
            dm_cnt    <= 8'((force_lat != 0) ? force_lat : dm_next);
            dm_next   <= int'($urandom_range(1, 8));
        end else if (dm_done) begin
            dm_active <= 1'b0;
        end else if (dm_active && !stuck && dm_cnt > 8'd1) begin
            dm_cnt <= dm_cnt - 8'd1;
        end
    end

    assign bus.div_done      = dm_done;
    assign bus.div_quotient  = (dm_done && dm_b != 0) ? dm_a / dm_b : 16'hDEAD;
    assign bus.div_remainder = (dm_done && dm_b != 0) ? {1'b0, dm_a % dm_b} : 17'h1BEEF;

    // Driver and reference model: round-robin grant, idle/busy tracking, expected results.
    int               m_rr   = 0;
    logic             m_idle = 1'b1;
    int               d_g;
    int               d_c;
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] hs;
    exp_t             d_e;
    int               n_start = 0;

    initial begin
        drv_valid      = '0;
        drv_resp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                drv_valid = '0;
                m_idle    = 1'b1;
                m_rr      = 0;
                exp_q.delete();
                continue;
            end
            d_g = -1;
            for (int k = 0; k < N_REQ; k++) begin
                d_c = (m_rr + k) % N_REQ;
                if (d_g < 0 && drv_valid[d_c]) d_g = d_c;
            end
            exp_ready = (m_idle && d_g >= 0) ? (N_REQ'(1) << d_g) : '0;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("busy", 32'(bus.busy), 32'(!m_idle));
            if (exp_ready != '0) begin
                d_e.id      = d_g;
                d_e.acc_cyc = cyc;
                d_e.starts  = n_start;
                if (drv_b[d_g] == 16'd0) begin
                    d_e.q = 16'hFFFF;  d_e.r = {1'b0, drv_a[d_g]};  d_e.err = 2'b01;
                end else if (stuck) begin
                    d_e.q = 16'd0;     d_e.r = 17'd0;               d_e.err = 2'b10;
                end else begin
                    d_e.q = drv_a[d_g] / drv_b[d_g];
                    d_e.r = {1'b0, drv_a[d_g] % drv_b[d_g]};
                    d_e.err = 2'b00;
                end
                exp_q.push_back(d_e);
                acc_log.push_back(d_g);
                m_rr   = (d_g + 1) % N_REQ;
                m_idle = 1'b0;
            end else if (!m_idle && bus.resp_valid && bus.resp_ready) begin
                m_idle = 1'b1;
            end
            hs = exp_ready;
            @(posedge clk);
            #1;
            if (rst) continue;
            for (int i = 0; i < N_REQ; i++) begin
                if (hs[i]) drv_valid[i] = 1'b0;
                if (!drv_valid[i] && (gap == 0 || $urandom_range(0, gap) == 0)) begin
                    for (int j = 0; j < op_q.size(); j++) begin
                        if (op_q[j].id == i) begin
                            drv_a[i]     = op_q[j].a;
                            drv_b[i]     = op_q[j].b;
                            drv_valid[i] = 1'b1;
                            op_q.delete(j);
                            break;
                        end
                    end
                end
            end
            case (rr_mode)
                0:       drv_resp_ready = 1'b1;
                1:       drv_resp_ready = 1'($urandom_range(0, 1));
                default: drv_resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_start = 1'b0;
    logic [ID_W-1:0] held_id;
    logic [15:0] held_q;
    logic [16:0] held_r;
    logic [1:0]  held_err;
    int          start_cyc = 0;
    int          rise_cyc  = 0;
    int          n_soft    = 0;
    int          lat_exp;
    exp_t        m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                prev_start = 1'b0;
                continue;
            end
            if (bus.div_start) begin
                chk("div_start_pulse", 32'(prev_start), 32'd0);
                n_start++;
                start_cyc = cyc;
            end
            if (bus.div_soft_rst) begin
                chk("soft_rst_spurious", 32'(stuck), 32'd1);
                chk("soft_rst_delay", 32'(cyc - start_cyc), 32'(TIMEOUT));
                n_soft++;
            end
            if (bus.resp_valid && !prev_valid) rise_cyc = cyc;
            if (bus.resp_valid && prev_valid && !prev_ready) begin
                chk("hold_id", 32'(bus.resp_id), 32'(held_id));
                chk("hold_quotient", 32'(bus.resp_quotient), 32'(held_q));
                chk("hold_remainder", 32'(bus.resp_remainder), 32'(held_r));
                chk("hold_err", 32'(bus.resp_err), 32'(held_err));
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL resp_unexpected: got id %0d with nothing outstanding", bus.resp_id);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(m_e.id));
                    chk("resp_quotient", 32'(bus.resp_quotient), 32'(m_e.q));
                    chk("resp_remainder", 32'(bus.resp_remainder), 32'(m_e.r));
                    chk("resp_err", 32'(bus.resp_err), 32'(m_e.err));
                    lat_exp = (m_e.err == 2'b01) ? 1 : (m_e.err == 2'b10) ? TIMEOUT + 2 : 2 + dm_lat;
                    chk("resp_latency", 32'(rise_cyc - m_e.acc_cyc), 32'(lat_exp));
                    chk("start_count", 32'(n_start), 32'(m_e.starts + ((m_e.err == 2'b01) ? 0 : 1)));
                end
            end
            prev_valid = bus.resp_valid;
            prev_ready = bus.resp_ready;
            prev_start = bus.div_start;
            held_id    = bus.resp_id;
            held_q     = bus.resp_quotient;
            held_r     = bus.resp_remainder;
            held_err   = bus.resp_err;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_div_start"}, 32'(bus.div_start), 32'd0);
        chk({tag, "_div_soft_rst"}, 32'(bus.div_soft_rst), 32'd0);
        chk({tag, "_div_dividend"}, 32'(bus.div_dividend), 32'd0);
        chk({tag, "_div_divisor"}, 32'(bus.div_divisor), 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        chk({tag, "_resp_quotient"}, 32'(bus.resp_quotient), 32'd0);
        chk({tag, "_resp_remainder"}, 32'(bus.resp_remainder), 32'd0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic push_op(input int id, input logic [15:0] a, input logic [15:0] b);
        op_t o;
        o.id = id;
        o.a  = a;
        o.b  = b;
        op_q.push_back(o);
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((op_q.size() != 0 || exp_q.size() != 0 || drv_valid != '0 || !m_idle) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 4000) begin
            n_bad++;
            $display("FAIL drain_%s: still busy after %0d cycles, %0d responses outstanding", nm, t, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int s0;
    int t;

    initial begin
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        // single request on requester 2
        push_op(2, 16'd100, 16'd7);
        wait_drain("single");

        // all requesters continuously valid from reset
        do_reset();
        acc_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++)
                push_op(i, 16'($urandom), 16'($urandom_range(1, 65535)));
        wait_drain("all_valid");
        for (int i = 0; i < 5; i++) chk("grant_order", 32'(acc_log[i]), 32'(exp_order[i]));

        // divide by zero
        push_op(1, 16'h1234, 16'd0);
        wait_drain("div0");

        // hung divider then a normal request
        s0 = n_soft;
        stuck = 1'b1;
        push_op(3, 16'd500, 16'd3);
        wait_drain("timeout");
        stuck = 1'b0;
        chk("soft_rst_count", 32'(n_soft - s0), 32'd1);
        push_op(3, 16'd500, 16'd3);
        wait_drain("after_timeout");

        // done on the last watchdog cycle beats the abort
        force_lat = TIMEOUT;
        push_op(0, 16'd999, 16'd10);
        wait_drain("done_vs_timeout");
        force_lat = 0;

        // back-pressure on the response channel
        rr_mode = 2;
        push_op(1, 16'd77, 16'd5);
        t = 0;
        while (!bus.resp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_resp_seen", 32'(bus.resp_valid), 32'd1);
        push_op(2, 16'd8, 16'd2);
        repeat (10) @(negedge clk);
        chk("bp_resp_held", 32'(bus.resp_valid), 32'd1);
        rr_mode = 0;
        wait_drain("backpressure");

        // reset while the divider is running
        stuck = 1'b1;
        s0 = n_start;
        push_op(2, 16'd50, 16'd5);
        t = 0;
        while (n_start == s0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        push_op(1, 16'd9, 16'd3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid_wait");
        repeat (2) @(negedge clk);
        stuck = 1'b0;
        op_q.delete();
        #2 rst = 1'b0;
        acc_log.delete();
        push_op(3, 16'd40, 16'd6);
        push_op(0, 16'd41, 16'd7);
        wait_drain("post_reset");
        chk("post_reset_first", 32'(acc_log[0]), 32'd0);
        chk("post_reset_second", 32'(acc_log[1]), 32'd3);

        // randomized traffic
        rr_mode = 1;
        gap = 3;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       push_op(int'($urandom_range(0, N_REQ-1)), 16'($urandom), 16'd0);
                1:       push_op(int'($urandom_range(0, N_REQ-1)), 16'($urandom), 16'($urandom_range(1, 255)));
                default: push_op(int'($urandom_range(0, N_REQ-1)), 16'($urandom), 16'($urandom_range(1, 65535)));
            endcase
        end
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
